// File: rtl/i8088_bus_pkg.sv
// Shared definitions for the 8088/8086 minimum-mode bus master: state encoding,
// counter sizing helper and configuration legality check.
package i8088_bus_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_T1   = 3'd1;
   localparam logic [2:0] ST_T2   = 3'd2;
   localparam logic [2:0] ST_T3   = 3'd3;
   localparam logic [2:0] ST_TW   = 3'd4;
   localparam logic [2:0] ST_T4   = 3'd5;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      T1   = ST_T1,
      T2   = ST_T2,
      T3   = ST_T3,
      TW   = ST_TW,
      T4   = ST_T4
   } bus_state_e;

   localparam int PHASE_MIN = 2;

   // Width of a counter holding 0..cycles-1, never narrower than one bit
   function automatic int phase_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

   function automatic bit data_w_legal(input int w);
      return (w == 8) || (w == 16);
   endfunction

endpackage

// File: rtl/i8088_ready_sync.sv
// Two-flop synchroniser bringing the asynchronous READY line into the clk domain.
module i8088_ready_sync
   import i8088_bus_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/i8088_bus_master.sv
// Minimum-mode 8088/8086 bus-cycle generator: T1-T2-T3-[Tw]-T4 from single-beat commands.
// Optional macro BUS_TIMEOUT_EN aborts a cycle after TIMEOUT_WAITS wait states.
module i8088_bus_master
   import i8088_bus_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int ADDR_W        = 20,
   parameter int PHASE_CYCLES  = 128,
   parameter int TIMEOUT_WAITS = 64
)
(
   input  logic                     CLK100MHZ,
   input  logic                     ck_rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic                     cmd_io,
   input  logic [ADDR_W-1:0]        cmd_addr,
   input  logic [DATA_W-1:0]        cmd_wdata,
   input  logic                     cmd_bhe_n,
   output logic                     rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_timeout,
   output logic                     ale,
   output logic                     nrd,
   output logic                     nwr,
   output logic                     io_nm,
   output logic                     dt_nr,
   output logic                     nden,
   output logic                     nbhe,
   output logic [ADDR_W-DATA_W-1:0] a_hi,
   output logic [DATA_W-1:0]        ad_out,
   output logic                     ad_oe,
   input  logic [DATA_W-1:0]        ad_in,
   input  logic                     ready_in
);

   localparam int PW = phase_width(PHASE_CYCLES);

   if (!data_w_legal(DATA_W) || PHASE_CYCLES < PHASE_MIN) begin : g_cfg_err
      $error("i8088_bus_master: DATA_W must be 8 or 16 and PHASE_CYCLES at least 2");
   end

   logic [2:0]        state;
   logic [PW-1:0]     phase;
   logic              phase_last;
   logic              rst_done;
   logic              ready_s;
   logic              timeout_hit;
   logic              timeout_q;
   logic              wr_q;
   logic              io_q;
   logic              bhe_n_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;

   i8088_ready_sync u_ready_sync (
      .clk   (CLK100MHZ),
      .rst_n (ck_rst),
      .d     (ready_in),
      .q     (ready_s)
   );

   assign phase_last = (phase == PW'(PHASE_CYCLES - 1));
   assign cmd_ready  = rst_done && (state == ST_IDLE) && !rsp_valid;

`ifdef BUS_TIMEOUT_EN
   localparam int WW = phase_width(TIMEOUT_WAITS + 1);
   logic [WW-1:0] wait_cnt;

   assign timeout_hit = (wait_cnt >= WW'(TIMEOUT_WAITS));

   // Counts Tw states entered; the abort flag is raised on the boundary where
   // one more wait would exceed the budget
   always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
      if (!ck_rst) begin
         wait_cnt    <= '0;
         timeout_q   <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_timeout <= (state == ST_T4 && phase_last) ? timeout_q : 1'b0;
         if (state == ST_T1) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
         end else if ((state == ST_T3 || state == ST_TW) && phase_last && !ready_s) begin
            if (timeout_hit)
               timeout_q <= 1'b1;
            else
               wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_q   = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   // Sequencer: every T/Tw state lasts PHASE_CYCLES clocks, decisions taken on the last one
   always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
      if (!ck_rst) begin
         state     <= ST_IDLE;
         phase     <= '0;
         rst_done  <= 1'b0;
         wr_q      <= 1'b0;
         io_q      <= 1'b0;
         bhe_n_q   <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rst_done  <= 1'b1;
         rsp_valid <= 1'b0;
         if (state == ST_IDLE) begin
            phase <= '0;
            if (cmd_valid && cmd_ready) begin
               wr_q    <= cmd_write;
               io_q    <= cmd_io;
               bhe_n_q <= cmd_bhe_n;
               addr_q  <= cmd_addr;
               wdata_q <= cmd_wdata;
               state   <= ST_T1;
            end
         end else begin
            phase <= phase_last ? '0 : phase + 1'b1;
            if (phase_last) begin
               case (state)
                  ST_T1: state <= ST_T2;
                  ST_T2: state <= ST_T3;
                  ST_T3, ST_TW: begin
                     if (ready_s) begin
                        if (!wr_q)
                           rdata_q <= ad_in;
                        state <= ST_T4;
                     end else if (timeout_hit) begin
                        state <= ST_T4;
                     end else begin
                        state <= ST_TW;
                     end
                  end
                  ST_T4: begin
                     state     <= ST_IDLE;
                     rsp_valid <= 1'b1;
                     if (timeout_q)
                        rsp_rdata <= '1;
                     else if (wr_q)
                        rsp_rdata <= '0;
                     else
                        rsp_rdata <= rdata_q;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   // Bus pins decode straight from state so a reset releases strobes immediately
   always_comb begin
      ale    = 1'b0;
      nrd    = 1'b1;
      nwr    = 1'b1;
      nden   = 1'b1;
      dt_nr  = 1'b1;
      io_nm  = 1'b0;
      nbhe   = 1'b1;
      a_hi   = '0;
      ad_out = '0;
      ad_oe  = 1'b0;
      if (state != ST_IDLE) begin
         io_nm = io_q;
         dt_nr = wr_q;
         a_hi  = addr_q[ADDR_W-1:DATA_W];
         nbhe  = (DATA_W == 16) ? bhe_n_q : 1'b1;
      end
      case (state)
         ST_T1: begin
            ale    = 1'b1;
            ad_out = addr_q[DATA_W-1:0];
            ad_oe  = 1'b1;
         end
         ST_T2, ST_T3, ST_TW: begin
            nden = 1'b0;
            if (wr_q) begin
               nwr    = 1'b0;
               ad_out = wdata_q;
               ad_oe  = 1'b1;
            end else begin
               nrd = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i8088_bus_master.sv
// Self-checking bench for i8088_bus_master: vector table, hand sequences and random
// commands scored against a transaction-level model of the bus protocol.
`timescale 1ns/1ps
module tb_i8088_bus_master;

   localparam int PC     = 4;
   localparam int TW_MAX = 2;
`ifdef BUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 8-bit instance
   logic        c8_valid = 1'b0, c8_write = 1'b0, c8_io = 1'b0, c8_bhe_n = 1'b1;
   logic [19:0] c8_addr  = '0;
   logic [7:0]  c8_wdata = '0;
   logic        c8_ready, r8_valid, r8_timeout;
   logic [7:0]  r8_rdata, ad_out8;
   logic        ale8, nrd8, nwr8, io_nm8, dt_nr8, nden8, nbhe8, ad_oe8;
   logic [11:0] a_hi8;
   logic [7:0]  ad_in8 = 8'h00;
   logic        ready8 = 1'b1;

   // 16-bit instance
   logic        c16_valid = 1'b0, c16_write = 1'b0, c16_io = 1'b0, c16_bhe_n = 1'b1;
   logic [19:0] c16_addr  = '0;
   logic [15:0] c16_wdata = '0;
   logic        c16_ready, r16_valid, r16_timeout;
   logic [15:0] r16_rdata, ad_out16;
   logic        ale16, nrd16, nwr16, io_nm16, dt_nr16, nden16, nbhe16, ad_oe16;
   logic [3:0]  a_hi16;
   logic [15:0] ad_in16 = 16'h0000;
   logic        ready16 = 1'b1;

   i8088_bus_master #(.DATA_W(8), .ADDR_W(20), .PHASE_CYCLES(PC), .TIMEOUT_WAITS(TW_MAX)) dut8 (
      .CLK100MHZ(clk), .ck_rst(rst_n),
      .cmd_valid(c8_valid), .cmd_ready(c8_ready), .cmd_write(c8_write), .cmd_io(c8_io),
      .cmd_addr(c8_addr), .cmd_wdata(c8_wdata), .cmd_bhe_n(c8_bhe_n),
      .rsp_valid(r8_valid), .rsp_rdata(r8_rdata), .rsp_timeout(r8_timeout),
      .ale(ale8), .nrd(nrd8), .nwr(nwr8), .io_nm(io_nm8), .dt_nr(dt_nr8), .nden(nden8),
      .nbhe(nbhe8), .a_hi(a_hi8), .ad_out(ad_out8), .ad_oe(ad_oe8), .ad_in(ad_in8),
      .ready_in(ready8));

   i8088_bus_master #(.DATA_W(16), .ADDR_W(20), .PHASE_CYCLES(PC), .TIMEOUT_WAITS(TW_MAX)) dut16 (
      .CLK100MHZ(clk), .ck_rst(rst_n),
      .cmd_valid(c16_valid), .cmd_ready(c16_ready), .cmd_write(c16_write), .cmd_io(c16_io),
      .cmd_addr(c16_addr), .cmd_wdata(c16_wdata), .cmd_bhe_n(c16_bhe_n),
      .rsp_valid(r16_valid), .rsp_rdata(r16_rdata), .rsp_timeout(r16_timeout),
      .ale(ale16), .nrd(nrd16), .nwr(nwr16), .io_nm(io_nm16), .dt_nr(dt_nr16), .nden(nden16),
      .nbhe(nbhe16), .a_hi(a_hi16), .ad_out(ad_out16), .ad_oe(ad_oe16), .ad_in(ad_in16),
      .ready_in(ready16));

   // Bus-side devices: byte memory plus an IO port answering addr^0x3C; data reads
   // as 0xEE while the device is still holding READY low
   bit [7:0]    bus_mem [int];
   logic [19:0] bus_addr8 = '0;
   always @(posedge clk) begin
      #2;
      if (ale8) bus_addr8 = {a_hi8, ad_out8};
      if (!nwr8 && !io_nm8) bus_mem[int'(bus_addr8)] = ad_out8;
      if (!nrd8)
         ad_in8 = !ready8 ? 8'hEE :
                  io_nm8 ? (bus_addr8[7:0] ^ 8'h3C) :
                  (bus_mem.exists(int'(bus_addr8)) ? bus_mem[int'(bus_addr8)] : 8'h00);
      else
         ad_in8 = 8'h00;
      ad_in16 = !nrd16 ? 16'hBEEF : 16'h0000;
   end

   int rsp_cnt8 = 0;
   always @(posedge clk) if (r8_valid) rsp_cnt8++;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: expected wait-state count from the READY trace; ready_s lags ready_in
   // by two clocks and is judged on the last clock of T3 and of each Tw
   bit [7:0] ref_mem [int];
   function automatic int modelWaits(input int lo_s, input int lo_len, output bit tmo);
      int d;
      tmo = 1'b0;
      for (int k = 0; k < 200; k++) begin
         d = (3 + k) * PC;
         if (!((d - 2) >= lo_s && (d - 2) < lo_s + lo_len)) return k;
         if (TO_EN && k == TW_MAX) begin
            tmo = 1'b1;
            return k;
         end
      end
      return -1;
   endfunction

   typedef struct {
      int         lat;
      logic [7:0] rdata;
      logic       tmo;
      int         ale_cyc;
      int         strb_cyc;
      int         den_cyc;
      int         bad;
      int         pulse_bad;
   } obs_t;

   task automatic applyStimulus(input logic wr, input logic io, input logic [19:0] addr,
                                input logic [7:0] wd, input logic bhe_n,
                                input int lo_s, input int lo_len, output obs_t o);
      int guard;
      o = '{lat: -1, rdata: 8'h00, tmo: 1'b0, ale_cyc: 0, strb_cyc: 0, den_cyc: 0, bad: 0, pulse_bad: 0};
      @(negedge clk);
      guard = 0;
      while (!c8_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!c8_ready) begin
         checkOutput("cmd_ready_wait", 32'd0, 32'd1);
         return;
      end
      c8_valid = 1'b1; c8_write = wr; c8_io = io; c8_addr = addr; c8_wdata = wd; c8_bhe_n = bhe_n;
      @(negedge clk);
      c8_valid = 1'b0;
      for (int n = 1; n <= 400; n++) begin
         ready8 = !(n >= lo_s && n < lo_s + lo_len);
         if (r8_valid) begin
            o.lat = n; o.rdata = r8_rdata; o.tmo = r8_timeout;
            if (c8_ready) o.pulse_bad++;
            break;
         end
         if (ale8) begin
            o.ale_cyc++;
            if (ad_out8 !== addr[7:0] || !ad_oe8) o.bad++;
         end
         if (!nden8) o.den_cyc++;
         if (wr) begin
            if (!nwr8) begin
               o.strb_cyc++;
               if (ad_out8 !== wd || !ad_oe8 || nden8) o.bad++;
            end
            if (!nrd8) o.bad++;
         end else begin
            if (!nrd8) begin
               o.strb_cyc++;
               if (nden8) o.bad++;
            end
            if (!nwr8) o.bad++;
            if (!ale8 && ad_oe8) o.bad++;
         end
         if (io_nm8 !== io || dt_nr8 !== wr || nbhe8 !== 1'b1 || a_hi8 !== addr[19:8]) o.bad++;
         @(negedge clk);
      end
      ready8 = 1'b1;
      @(negedge clk);
      if (r8_valid || !c8_ready) o.pulse_bad++;
   endtask

   task automatic scoreTxn(input string tag, input logic wr, input logic io, input logic [19:0] addr,
                           input logic [7:0] wd, input int lo_s, input int lo_len, input obs_t o);
      bit         tmo;
      int         nw;
      logic [7:0] erd;
      nw = modelWaits(lo_s, lo_len, tmo);
      if (tmo) erd = 8'hFF;
      else if (wr) erd = 8'h00;
      else if (io) erd = addr[7:0] ^ 8'h3C;
      else erd = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'h00;
      if (wr && !io) ref_mem[int'(addr)] = wd;
      checkOutput({tag, ".latency"}, o.lat, (4 + nw) * PC + 1);
      checkOutput({tag, ".rdata"}, {24'd0, o.rdata}, {24'd0, erd});
      checkOutput({tag, ".timeout"}, {31'd0, o.tmo}, {31'd0, tmo});
      checkOutput({tag, ".ale_cycles"}, o.ale_cyc, PC);
      checkOutput({tag, ".strobe_cycles"}, o.strb_cyc, (2 + nw) * PC);
      checkOutput({tag, ".nden_cycles"}, o.den_cyc, (2 + nw) * PC);
      checkOutput({tag, ".pin_errors"}, o.bad, 0);
      checkOutput({tag, ".handshake"}, o.pulse_bad, 0);
   endtask

   typedef struct {
      logic       wr;
      logic       io;
      logic [19:0] addr;
      logic [7:0] wd;
      int         lo_s;
      int         lo_len;
      int         exp_lat;
      logic [7:0] exp_rd;
      logic       exp_to;
   } vec_t;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t  vecs [8];
      obs_t  o;
      int    cnt0;
      int    n16;
      string tag;

      vecs[0] = '{1'b1, 1'b1, 20'h00080, 8'h03, 0, 0,  17, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 20'h00008, 8'hA5, 0, 0,  17, 8'h00, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 20'h00000, 8'h5A, 0, 0,  17, 8'h00, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 20'h00000, 8'h00, 0, 0,  17, 8'h5A, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 20'h00008, 8'h00, 0, 0,  17, 8'hA5, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 20'hFFFF0, 8'h77, 0, 0,  17, 8'h00, 1'b0};
`ifdef BUS_TIMEOUT_EN
      vecs[6] = '{1'b0, 1'b0, 20'hFFFF0, 8'h00, 9, 10, 25, 8'hFF, 1'b1};
      vecs[7] = '{1'b0, 1'b0, 20'h00123, 8'h00, 1, 60, 25, 8'hFF, 1'b1};
`else
      vecs[6] = '{1'b0, 1'b0, 20'hFFFF0, 8'h00, 9, 10, 29, 8'h77, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 20'h00123, 8'h00, 1, 60, 69, 8'h00, 1'b0};
`endif

      // Reset values
      #2;
      checkOutput("reset.pins", {24'd0, ale8, nrd8, nwr8, nden8, dt_nr8, io_nm8, nbhe8, ad_oe8}, 32'h7A);
      checkOutput("reset.bus", {12'd0, a_hi8, ad_out8}, 32'd0);
      checkOutput("reset.rsp", {22'd0, r8_valid, r8_timeout, r8_rdata}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("reset.cmd_ready_low", {31'd0, c8_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("reset.cmd_ready_before_clock", {31'd0, c8_ready}, 32'd0);
      @(negedge clk);
      checkOutput("reset.cmd_ready_after_clock", {31'd0, c8_ready}, 32'd1);

      // Vector table
      for (int i = 0; i < 8; i++) begin
         tag = $sformatf("vec%0d", i);
         applyStimulus(vecs[i].wr, vecs[i].io, vecs[i].addr, vecs[i].wd, 1'b0,
                       vecs[i].lo_s, vecs[i].lo_len, o);
         checkOutput({tag, ".table_latency"}, o.lat, vecs[i].exp_lat);
         checkOutput({tag, ".table_rdata"}, {24'd0, o.rdata}, {24'd0, vecs[i].exp_rd});
         checkOutput({tag, ".table_timeout"}, {31'd0, o.tmo}, {31'd0, vecs[i].exp_to});
         scoreTxn(tag, vecs[i].wr, vecs[i].io, vecs[i].addr, vecs[i].wd, vecs[i].lo_s, vecs[i].lo_len, o);
      end

      // cmd_valid held while busy must not start a second cycle
      @(negedge clk);
      cnt0 = rsp_cnt8;
      c8_valid = 1'b1; c8_write = 1'b1; c8_io = 1'b1; c8_addr = 20'h00040; c8_wdata = 8'h11;
      @(negedge clk);
      c8_write = 1'b0; c8_io = 1'b0; c8_addr = 20'h00300;
      repeat (12) @(negedge clk);
      c8_valid = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("busy.single_response", rsp_cnt8 - cnt0, 1);

      // Reset during T2 of an IO write
      c8_valid = 1'b1; c8_write = 1'b1; c8_io = 1'b1; c8_addr = 20'h00081; c8_wdata = 8'h3C;
      @(negedge clk);
      c8_valid = 1'b0;
      for (int n = 0; n < 20 && nwr8; n++) @(negedge clk);
      checkOutput("midreset.nwr_reached", {31'd0, nwr8}, 32'd0);
      cnt0 = rsp_cnt8;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset.async_pins", {28'd0, nwr8, ad_oe8, nden8, ale8}, 32'b1010);
      checkOutput("midreset.cmd_ready", {31'd0, c8_ready}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midreset.cmd_ready_release", {31'd0, c8_ready}, 32'd0);
      @(negedge clk);
      checkOutput("midreset.cmd_ready_next", {31'd0, c8_ready}, 32'd1);
      repeat (30) @(negedge clk);
      checkOutput("midreset.no_response", rsp_cnt8 - cnt0, 0);

      // 16-bit data path read with BHE asserted
      c16_valid = 1'b1; c16_write = 1'b0; c16_io = 1'b0; c16_addr = 20'h12345; c16_bhe_n = 1'b0;
      @(negedge clk);
      c16_valid = 1'b0;
      checkOutput("w16.t1_ale", {31'd0, ale16}, 32'd1);
      checkOutput("w16.t1_a_hi", {28'd0, a_hi16}, 32'h1);
      checkOutput("w16.t1_ad_out", {16'd0, ad_out16}, 32'h2345);
      checkOutput("w16.t1_nbhe", {31'd0, nbhe16}, 32'd0);
      n16 = -1;
      for (int n = 1; n <= 100; n++) begin
         if (r16_valid) begin
            n16 = n;
            break;
         end
         @(negedge clk);
      end
      checkOutput("w16.latency", n16, 17);
      checkOutput("w16.rdata", {16'd0, r16_rdata}, 32'hBEEF);

      // Random commands against the model
      for (int i = 0; i < 40; i++) begin
         logic        wr, io, bhe;
         logic [19:0] addr;
         logic [7:0]  wd;
         int          lo_s, lo_len;
         wr   = 1'($urandom_range(0, 1));
         io   = ($urandom_range(0, 3) == 0);
         bhe  = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 1) ? 20'hF0000 : 20'h00000) | 20'($urandom_range(0, 31));
         wd   = 8'($urandom);
         lo_s = $urandom_range(1, 9);
         lo_len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 24) : 0;
         applyStimulus(wr, io, addr, wd, bhe, lo_s, lo_len, o);
         scoreTxn($sformatf("rnd%0d", i), wr, io, addr, wd, lo_s, lo_len, o);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
